// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared types for the out-of-order MIPS core.
// Holds the reorder-buffer instruction kinds, the default ROB configuration
// and the layout of one ROB entry at that default configuration.
package mips_core_pkg;

  // Instruction kinds as encoded on alloc_type / commit_type.
  typedef enum logic [1:0] {
    ROB_REG = 2'd0,
    ROB_JU  = 2'd1,
    ROB_ST  = 2'd2,
    ROB_BR  = 2'd3
  } rob_inst_t;

  localparam int ROB_DEPTH     = 16;
  localparam int ROB_COMMIT_W  = 2;
  localparam int ROB_CDB_PORTS = 2;
  localparam int ROB_DATA_W    = 32;
  localparam int ROB_ADDR_W    = 16;
  localparam int ROB_PREG_W    = 6;

  // One ROB entry at the default widths.
  typedef struct packed {
    logic                  valid;
    logic                  ready;
    rob_inst_t             itype;
    logic                  jump_reg;
    logic [4:0]            ldest;
    logic [ROB_PREG_W-1:0] pdest;
    logic [ROB_DATA_W-1:0] value;
    logic [ROB_ADDR_W-1:0] mem_addr;
  } rob_entry_t;

  // Only a direct jump (j/jal) knows everything it needs at decode time.
  function automatic logic readyOnAlloc(input rob_inst_t itype, input logic jumpReg);
    return (itype == ROB_JU) && !jumpReg;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select: decides which of the COMMIT_W head-window slots retire
// this cycle. Slot 0 is the oldest entry. The result is always a contiguous
// run of ones starting at slot 0.
// Ports:
//   valid_i/ready_i/jump_reg_i  per-slot entry state
//   type_i                      per-slot rob_inst_t, 2 bits per slot
//   st_stall_i                  memory cannot take a store this cycle
//   commit_o                    per-slot retire mask
module rob_commit_select
  import mips_core_pkg::*;
#(
  parameter int COMMIT_W = ROB_COMMIT_W
) (
  input  logic [COMMIT_W-1:0]   valid_i,
  input  logic [COMMIT_W-1:0]   ready_i,
  input  logic [COMMIT_W-1:0]   jump_reg_i,
  input  logic [2*COMMIT_W-1:0] type_i,
  input  logic                  st_stall_i,
  output logic [COMMIT_W-1:0]   commit_o
);

  // inOrder drops once a slot fails to retire, or after a control-flow slot
  // retires, so nothing younger can slip past it. Only one store port exists.
  always_comb begin
    logic      inOrder;
    logic      stSeen;
    logic      canGo;
    rob_inst_t slotType;
    inOrder  = 1'b1;
    stSeen   = 1'b0;
    canGo    = 1'b0;
    slotType = ROB_REG;
    commit_o = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      slotType = rob_inst_t'(type_i[2*i +: 2]);
      canGo    = inOrder && valid_i[i] && ready_i[i];
      if (slotType == ROB_ST && (stSeen || st_stall_i)) begin
        canGo = 1'b0;
      end
      commit_o[i] = canGo;
      if (!canGo) begin
        inOrder = 1'b0;
      end
      if (canGo && slotType == ROB_ST) begin
        stSeen = 1'b1;
      end
      if (canGo && (slotType == ROB_BR || (slotType == ROB_JU && jump_reg_i[i]))) begin
        inOrder = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with multi-slot in-order commit.
// Allocates one entry per cycle from decode, captures results from the CDB
// ports and the store address unit, retires up to COMMIT_W entries per cycle
// and supports full flush plus squash of entries younger than a branch.
// Ports:
//   alloc_*   allocation request / ready / next tag, count = occupancy
//   cdb_*     result write-back ports (flattened, port p at slice p)
//   st_*      store address/data resolution, st_stall blocks store commit
//   flush, squash_valid/squash_tag   recovery
//   commit_*, reg_wr_*, mem_wr_*, br_*, jr_*   retirement outputs
module rob_multi_commit
  import mips_core_pkg::*;
#(
  parameter int DEPTH     = ROB_DEPTH,
  parameter int COMMIT_W  = ROB_COMMIT_W,
  parameter int CDB_PORTS = ROB_CDB_PORTS,
  parameter int DATA_W    = ROB_DATA_W,
  parameter int ADDR_W    = ROB_ADDR_W,
  parameter int PREG_W    = ROB_PREG_W,
  parameter int TAG_W     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc_valid,
  input  logic [1:0]                  alloc_type,
  input  logic                        alloc_jump_reg,
  input  logic [4:0]                  alloc_ldest,
  input  logic [PREG_W-1:0]           alloc_pdest,
  output logic                        alloc_ready,
  output logic [TAG_W-1:0]            alloc_tag,
  output logic [TAG_W:0]              count,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  input  logic                        st_valid,
  input  logic [TAG_W-1:0]            st_tag,
  input  logic [ADDR_W-1:0]           st_addr,
  input  logic [DATA_W-1:0]           st_data,
  input  logic                        st_stall,
  input  logic                        flush,
  input  logic                        squash_valid,
  input  logic [TAG_W-1:0]            squash_tag,
  output logic [COMMIT_W-1:0]         commit_valid,
  output logic [2*COMMIT_W-1:0]       commit_type,
  output logic [COMMIT_W-1:0]         reg_wr_en,
  output logic [COMMIT_W*PREG_W-1:0]  reg_wr_paddr,
  output logic [COMMIT_W*5-1:0]       reg_wr_laddr,
  output logic [COMMIT_W*DATA_W-1:0]  reg_wr_data,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_wr_addr,
  output logic [DATA_W-1:0]           mem_wr_data,
  output logic                        br_valid,
  output logic                        br_taken,
  output logic                        jr_valid,
  output logic [ADDR_W-1:0]           jr_target
);

  typedef struct packed {
    logic              valid;
    logic              ready;
    rob_inst_t         itype;
    logic              jump_reg;
    logic [4:0]        ldest;
    logic [PREG_W-1:0] pdest;
    logic [DATA_W-1:0] value;
    logic [ADDR_W-1:0] mem_addr;
  } entry_t;

  entry_t entries_q [DEPTH];
  entry_t entries_d [DEPTH];

  // Pointers carry one wrap bit so full and empty can be told apart.
  logic [TAG_W:0]   rdPtr_q, rdPtr_d;
  logic [TAG_W:0]   wrPtr_q, wrPtr_d;
  logic [TAG_W-1:0] rdIdx, wrIdx;
  logic             full;

  logic [TAG_W-1:0]    winIdx [COMMIT_W];
  logic [COMMIT_W-1:0] winValid, winReady, winJumpReg;
  logic [2*COMMIT_W-1:0] winType;
  logic [TAG_W:0]      commitCount;

  logic [TAG_W-1:0] squashDist;
  logic [TAG_W:0]   keepLen;

  assign rdIdx       = rdPtr_q[TAG_W-1:0];
  assign wrIdx       = wrPtr_q[TAG_W-1:0];
  assign full        = (rdIdx == wrIdx) && (rdPtr_q[TAG_W] != wrPtr_q[TAG_W]);
  assign alloc_ready = !full;
  assign alloc_tag   = wrIdx;
  assign count       = wrPtr_q - rdPtr_q;

  // Distance of the squashing branch from the head; it and everything older
  // survive, so the surviving run is one entry longer than the distance.
  assign squashDist = squash_tag - rdIdx;
  assign keepLen    = {1'b0, squashDist} + (TAG_W+1)'(1);

  // Gather the head window, slot i being the i-th oldest entry.
  always_comb begin
    winValid   = '0;
    winReady   = '0;
    winJumpReg = '0;
    winType    = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      winIdx[i]         = rdIdx + TAG_W'(i);
      winValid[i]       = entries_q[winIdx[i]].valid;
      winReady[i]       = entries_q[winIdx[i]].ready;
      winJumpReg[i]     = entries_q[winIdx[i]].jump_reg;
      winType[2*i +: 2] = entries_q[winIdx[i]].itype;
    end
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W)
  ) u_commit_select (
    .valid_i    (winValid),
    .ready_i    (winReady),
    .jump_reg_i (winJumpReg),
    .type_i     (winType),
    .st_stall_i (st_stall),
    .commit_o   (commit_valid)
  );

  always_comb begin
    commitCount = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      commitCount = commitCount + (TAG_W+1)'(commit_valid[i]);
    end
  end

  // Retirement outputs are zero unless their slot actually commits, so
  // downstream units can use the data fields without re-qualifying them.
  always_comb begin
    commit_type  = '0;
    reg_wr_en    = '0;
    reg_wr_paddr = '0;
    reg_wr_laddr = '0;
    reg_wr_data  = '0;
    mem_wr_en    = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    br_valid     = 1'b0;
    br_taken     = 1'b0;
    jr_valid     = 1'b0;
    jr_target    = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid[i]) begin
        commit_type[2*i +: 2] = entries_q[winIdx[i]].itype;
        if (entries_q[winIdx[i]].itype == ROB_REG && entries_q[winIdx[i]].ldest != 5'd0) begin
          reg_wr_en[i]                  = 1'b1;
          reg_wr_paddr[i*PREG_W +: PREG_W] = entries_q[winIdx[i]].pdest;
          reg_wr_laddr[i*5 +: 5]        = entries_q[winIdx[i]].ldest;
          reg_wr_data[i*DATA_W +: DATA_W] = entries_q[winIdx[i]].value;
        end
        if (entries_q[winIdx[i]].itype == ROB_ST) begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = entries_q[winIdx[i]].mem_addr;
          mem_wr_data = entries_q[winIdx[i]].value;
        end
        if (entries_q[winIdx[i]].itype == ROB_BR) begin
          br_valid = 1'b1;
          br_taken = |entries_q[winIdx[i]].value;
        end
        if (entries_q[winIdx[i]].itype == ROB_JU && entries_q[winIdx[i]].jump_reg) begin
          jr_valid  = 1'b1;
          jr_target = entries_q[winIdx[i]].value[ADDR_W-1:0];
        end
      end
    end
  end

  // Next state. Later statements override earlier ones: result capture,
  // then commit clears, then flush or squash, and allocation only when no
  // recovery is in progress. Result writes test the start-of-cycle valid bit
  // so a write never lands in a slot being allocated this same cycle.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      entries_d[j] = entries_q[j];
    end
    rdPtr_d = rdPtr_q + commitCount;
    wrPtr_d = wrPtr_q;

    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && entries_q[cdb_tag[p*TAG_W +: TAG_W]].valid) begin
        entries_d[cdb_tag[p*TAG_W +: TAG_W]].value = cdb_data[p*DATA_W +: DATA_W];
        entries_d[cdb_tag[p*TAG_W +: TAG_W]].ready = 1'b1;
      end
    end
    if (st_valid && entries_q[st_tag].valid) begin
      entries_d[st_tag].value    = st_data;
      entries_d[st_tag].mem_addr = st_addr;
      entries_d[st_tag].ready    = 1'b1;
    end

    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid[i]) begin
        entries_d[winIdx[i]] = '0;
      end
    end

    if (flush) begin
      for (int j = 0; j < DEPTH; j++) begin
        entries_d[j] = '0;
      end
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else if (squash_valid) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((TAG_W'(j) - rdIdx) > squashDist) begin
          entries_d[j] = '0;
        end
      end
      // If commits already consumed the whole surviving run, the buffer is empty.
      wrPtr_d = (commitCount > keepLen) ? rdPtr_d : (rdPtr_q + keepLen);
    end else if (alloc_valid && !full) begin
      entries_d[wrIdx].valid    = 1'b1;
      entries_d[wrIdx].ready    = readyOnAlloc(rob_inst_t'(alloc_type), alloc_jump_reg);
      entries_d[wrIdx].itype    = rob_inst_t'(alloc_type);
      entries_d[wrIdx].jump_reg = alloc_jump_reg;
      entries_d[wrIdx].ldest    = alloc_ldest;
      entries_d[wrIdx].pdest    = alloc_pdest;
      entries_d[wrIdx].value    = '0;
      entries_d[wrIdx].mem_addr = '0;
      wrPtr_d = wrPtr_q + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        entries_q[j] <= '0;
      end
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      for (int j = 0; j < DEPTH; j++) begin
        entries_q[j] <= entries_d[j];
      end
    end
  end

endmodule
